// File: rtl/io_cond_pkg.sv
// Shared defaults and the counter-width rule for the io_in conditioning front-end.
package io_cond_pkg;

  localparam int unsigned DEF_WIDTH           = 8;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;

  // Counter must hold DEBOUNCE_CYCLES-1 with headroom for the compare.
  function automatic int unsigned cnt_width(input int unsigned debounce_cycles);
    return int'($clog2(debounce_cycles)) + 1;
  endfunction

endpackage

// File: rtl/debounce_lane.sv
// One input bit: 2-FF synchronizer, consecutive-mismatch debouncer, edge pulses.
module debounce_lane
  import io_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic accept_c
);

  localparam int unsigned    CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Acceptance fires on the edge where the mismatch streak completes.
  assign accept_c = (s2 != clean) && (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 == clean) begin
        cnt <= '0;
      end else if (accept_c) begin
        clean <= s2;
        cnt   <= '0;
        rise  <= s2;
        fall  <= ~s2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/io_in_conditioner.sv
// Conditions raw asynchronous pins into clean levels plus rise/fall/event pulses.
module io_in_conditioner
  import io_cond_pkg::*;
#(
  parameter int unsigned WIDTH           = DEF_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_out,
  output logic [WIDTH-1:0] fall_out,
  output logic             event_out
);

  logic [WIDTH-1:0] lane_accept_c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    debounce_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .din     (io_in[i]),
      .clean   (clean_out[i]),
      .rise    (rise_out[i]),
      .fall    (fall_out[i]),
      .accept_c(lane_accept_c[i])
    );
  end

  // Registered from the lanes' acceptance terms so it lines up with their pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_out <= 1'b0;
    end else begin
      event_out <= |lane_accept_c;
    end
  end

endmodule
